queue_write_arbiter: RTL and testbench
======================================

QUEUE_WRITE_ARBITER -- requirements
Module: queue_write_arbiter

Interface
REQ-001 SHALL have parameter num_requesters, default 4, number of producers sharing the queue write port.
REQ-002 SHALL have parameter word_length, default 8, width of each data word.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req, input, num_requesters, per-producer write request, held until granted.
REQ-006 SHALL have port req_data, input, num_requesters*word_length, producer i word at bits [i*word_length +: word_length].
REQ-007 SHALL have port stack_full, input, 1, full flag from the queue.
REQ-008 SHALL have port grant, output, num_requesters, one-hot registered grant; its pulse means the word was taken.
REQ-009 SHALL have port write_to_stack, output, 1, registered queue write strobe.
REQ-010 SHALL have port data_to_stack, output, word_length, registered word to the queue.
REQ-011 SHALL have port blocked, output, 1, high while requests are pending and stack_full is high.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE and FULL_WAIT.
REQ-013 SHALL, in any state at a rising edge, go to WRITE when an eligible request exists and stack_full is low; go to FULL_WAIT when an eligible request exists and stack_full is high; otherwise go to IDLE.
REQ-014 SHALL treat as eligible every req bit except the one granted in the current cycle. This masking prevents double-granting a producer that cannot drop req until the next cycle.
REQ-015 SHALL pick the winner round-robin: the first eligible index at or above rr_ptr, wrapping from num_requesters-1 to 0.
REQ-016 SHALL, on entering WRITE, set grant to one-hot winner, write_to_stack to 1 and data_to_stack to the winner's req_data slice, all in the same cycle. Latency is one cycle from req sampled to grant/write.
REQ-017 SHALL set rr_ptr to winner+1 modulo num_requesters on each grant. rr_ptr is unchanged when no grant is issued.
REQ-018 SHALL hold grant at 0 and write_to_stack at 0 in IDLE and FULL_WAIT. data_to_stack holds its last value.
REQ-019 SHALL drive blocked high exactly while in FULL_WAIT.
REQ-020 SHALL allow back-to-back writes every cycle to different producers, or to the same producer after one masked cycle.
REQ-021 SHALL never assert write_to_stack on a cycle following an edge at which stack_full was sampled high.
REQ-022 SHALL, when only one producer requests continuously, grant it every second cycle (WRITE, then IDLE because it is masked, then WRITE).
REQ-023 SHALL ignore req_data of non-winning producers.

Reset
REQ-024 SHALL, while reset is low and regardless of clk, force state to IDLE, grant to 0, write_to_stack to 0, data_to_stack to 0, blocked to 0 and rr_ptr to 0.
REQ-025 SHALL, when reset is asserted mid-WRITE, clear the in-flight grant and write immediately. The producer keeps req high and is re-arbitrated after release.
REQ-026 SHALL perform the first arbitration at the first rising edge after reset rises.

Structure
REQ-027 SHALL place the state encoding (IDLE, WRITE, FULL_WAIT) and the default word_length and num_requesters in a shared package queue_pkg, used by the queue FSM as well.
REQ-028 SHALL implement the round-robin pick (masked req, rr_ptr in; one-hot winner and valid out) as the combinational sub-module rr_pick.
REQ-029 SHALL require no storage beyond state, rr_ptr and the output registers.

Verification
REQ-030 SHALL cover: req=4'b0101, stack_full=0 -> grant 0001 (data slice 0) next cycle, then 0100, then 0001; write_to_stack high on each.
REQ-031 SHALL cover: req=4'b1111 held, stack_full=0 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with rr_ptr wrap from 3 to 0.
REQ-032 SHALL cover: single req=4'b0010 held -> grant pattern 0010, 0000, 0010, 0000.
REQ-033 SHALL cover: req=4'b0001 with stack_full=1 for 3 cycles -> blocked=1, grant=0, write_to_stack=0; when stack_full drops, grant 0001 on the next edge.
REQ-034 SHALL cover: reset driven low between edges while grant=0100 -> grant, write_to_stack and data_to_stack are 0 before the next edge; after release with req=4'b0100, the first grant is 0100.
REQ-035 SHALL cover: 32 writes from 4 producers into a 32-deep queue followed by a 33rd request -> exactly 32 write_to_stack pulses, then FULL_WAIT.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared definitions for the queue write path.
//
// Holds the arbiter/queue FSM state encoding and the default sizing used by
// queue_write_arbiter, its bus interface and the queue FSM.
package queue_pkg;

  localparam int unsigned default_num_requesters = 4;
  localparam int unsigned default_word_length    = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    FULL_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/queue_write_arbiter_if.sv
// Bus between the producers / queue and queue_write_arbiter.
//
// Signals:
//   req            per-producer write request, held until granted
//   req_data       producer i word at [i*word_length +: word_length]
//   stack_full     full flag from the queue
//   grant          one-hot registered grant (pulse = word taken)
//   write_to_stack registered queue write strobe
//   data_to_stack  registered word to the queue
//   blocked        high while pending requests are stalled by stack_full
//
// Modports:
//   master  producers + queue side (drives req/req_data/stack_full)
//   slave   arbiter side
interface queue_write_arbiter_if
  import queue_pkg::*;
#(
  parameter int unsigned num_requesters = default_num_requesters,
  parameter int unsigned word_length    = default_word_length
);

  logic [num_requesters-1:0]             req;
  logic [num_requesters*word_length-1:0] req_data;
  logic                                  stack_full;
  logic [num_requesters-1:0]             grant;
  logic                                  write_to_stack;
  logic [word_length-1:0]                data_to_stack;
  logic                                  blocked;

  modport master (
    output req,
    output req_data,
    output stack_full,
    input  grant,
    input  write_to_stack,
    input  data_to_stack,
    input  blocked
  );

  modport slave (
    input  req,
    input  req_data,
    input  stack_full,
    output grant,
    output write_to_stack,
    output data_to_stack,
    output blocked
  );

endinterface

// File: rtl/queue_write_arbiter_rr_pick.sv
// Combinational round-robin pick.
//
// Ports:
//   eligible  requests allowed to compete this cycle
//   rr_ptr    index with highest priority this cycle
//   winner    one-hot winner: first eligible index at or above rr_ptr,
//             wrapping from num_requesters-1 to 0
//   valid     high when any request is eligible
module rr_pick #(
  parameter int unsigned num_requesters = 4,
  parameter int unsigned ptr_width      = 2
) (
  input  logic [num_requesters-1:0] eligible,
  input  logic [ptr_width-1:0]      rr_ptr,
  output logic [num_requesters-1:0] winner,
  output logic                      valid
);

  always_comb begin
    int unsigned idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    // Walk the ring starting at rr_ptr; the first hit wins.
    for (int unsigned off = 0; off < num_requesters; off++) begin
      idx = 32'(rr_ptr) + off;
      if (idx >= num_requesters) begin
        idx = idx - num_requesters;
      end
      if (!valid && eligible[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/queue_write_arbiter.sv
// Round-robin arbiter sharing one queue write port between producers.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    queue_write_arbiter_if slave modport (req, req_data, stack_full in;
//          grant, write_to_stack, data_to_stack, blocked out)
//
// Every edge re-arbitrates: a winner with stack_full low is written (grant,
// strobe and data registered together, one cycle after req is sampled); a
// winner with stack_full high parks the FSM in FULL_WAIT (blocked).
module queue_write_arbiter
  import queue_pkg::*;
#(
  parameter int unsigned num_requesters = default_num_requesters,
  parameter int unsigned word_length    = default_word_length
) (
  input logic                  clk,
  input logic                  reset,
  queue_write_arbiter_if.slave bus
);

  localparam int unsigned ptr_width =
    (num_requesters > 1) ? $clog2(num_requesters) : 1;

  state_t                    state;
  state_t                    state_next;
  logic [ptr_width-1:0]      rr_ptr;
  logic [ptr_width-1:0]      rr_ptr_next;
  logic [ptr_width-1:0]      win_idx;
  logic [num_requesters-1:0] eligible;
  logic [num_requesters-1:0] winner;
  logic                      win_valid;
  logic [num_requesters-1:0] grant_q;
  logic [num_requesters-1:0] grant_next;
  logic                      write_q;
  logic                      write_next;
  logic [word_length-1:0]    data_q;
  logic [word_length-1:0]    data_next;
  logic [word_length-1:0]    win_data;

  // The producer granted this cycle still shows req until the next edge, so
  // it is kept out of the competition to avoid taking its word twice.
  assign eligible = bus.req & ~grant_q;

  rr_pick #(
    .num_requesters(num_requesters),
    .ptr_width     (ptr_width)
  ) u_rr_pick (
    .eligible(eligible),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .valid   (win_valid)
  );

  // Winner index and its data slice (one-hot AND-OR mux).
  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int unsigned i = 0; i < num_requesters; i++) begin
      if (winner[i]) begin
        win_idx  = ptr_width'(i);
        win_data = win_data | bus.req_data[i*word_length +: word_length];
      end
    end
  end

  // Next state and next output register values.
  always_comb begin
    state_next  = IDLE;
    grant_next  = '0;
    write_next  = 1'b0;
    data_next   = data_q;
    rr_ptr_next = rr_ptr;
    if (win_valid) begin
      if (!bus.stack_full) begin
        state_next  = WRITE;
        grant_next  = winner;
        write_next  = 1'b1;
        data_next   = win_data;
        rr_ptr_next = (win_idx == ptr_width'(num_requesters - 1))
                      ? '0 : win_idx + ptr_width'(1);
      end else begin
        state_next = FULL_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant_q <= '0;
      write_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state   <= state_next;
      rr_ptr  <= rr_ptr_next;
      grant_q <= grant_next;
      write_q <= write_next;
      data_q  <= data_next;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.write_to_stack = write_q;
  assign bus.data_to_stack  = data_q;
  assign bus.blocked        = (state == FULL_WAIT);

endmodule

// File: tb/tb_queue_write_arbiter.sv
module tb_queue_write_arbiter;

  localparam int unsigned n = 4;
  localparam int unsigned w = 8;

  logic clk;
  logic reset;

  queue_write_arbiter_if #(.num_requesters(n), .word_length(w)) bus ();

  queue_write_arbiter #(
    .num_requesters(n),
    .word_length   (w)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [n-1:0] grant;
    logic         write;
    logic [w-1:0] data;
    logic         blocked;
    string        name;
  } exp_t;

  typedef struct {
    logic         restart;
    logic [n-1:0] req;
    logic         sf;
    logic [n-1:0] grant;
    logic         write;
    logic         blocked;
  } vec_t;

  exp_t          sb[$];
  vec_t          vecs[$];
  int            checks;
  int            errors;
  logic [w-1:0]  last_data;
  logic [n*w-1:0] data_word;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [w-1:0] pick_word(input logic [n-1:0] g);
    pick_word = '0;
    for (int i = 0; i < n; i++) begin
      if (g[i]) pick_word = data_word[i*w +: w];
    end
  endfunction

  task automatic expect_out(input string name, input logic [n-1:0] g,
                            input logic wr, input logic bl);
    exp_t e;
    if (wr) last_data = pick_word(g);
    e.name    = name;
    e.grant   = g;
    e.write   = wr;
    e.data    = last_data;
    e.blocked = bl;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      cmp("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      cmp({e.name, "_grant"},   32'(bus.grant),          32'(e.grant));
      cmp({e.name, "_write"},   32'(bus.write_to_stack), 32'(e.write));
      cmp({e.name, "_data"},    32'(bus.data_to_stack),  32'(e.data));
      cmp({e.name, "_blocked"}, 32'(bus.blocked),        32'(e.blocked));
    end
  endtask

  // Returns at a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b0;
    bus.req        = '0;
    bus.stack_full = 1'b0;
    last_data      = '0;
    #2;
    cmp("rst_grant",   32'(bus.grant),          32'd0);
    cmp("rst_write",   32'(bus.write_to_stack), 32'd0);
    cmp("rst_data",    32'(bus.data_to_stack),  32'd0);
    cmp("rst_blocked", 32'(bus.blocked),        32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic add(input logic r, input logic [n-1:0] rq, input logic sf,
                     input logic [n-1:0] g, input logic wr, input logic bl);
    vec_t v;
    v.restart = r; v.req = rq; v.sf = sf;
    v.grant = g; v.write = wr; v.blocked = bl;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int pend[n];
    int written;
    int bad;
    int full_cycles;
    int left;
    logic sf_at_edge;

    checks         = 0;
    errors         = 0;
    reset          = 1'b0;
    data_word      = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus.req_data   = data_word;
    bus.req        = '0;
    bus.stack_full = 1'b0;
    last_data      = '0;

    // Two requesters alternate.
    add(1'b1, 4'b0101, 1'b0, 4'b0001, 1'b1, 1'b0);
    add(1'b0, 4'b0101, 1'b0, 4'b0100, 1'b1, 1'b0);
    add(1'b0, 4'b0101, 1'b0, 4'b0001, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    // All four held: full rotation and wrap.
    add(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b0);
    // Single requester: every second cycle.
    add(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0);
    add(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0);
    add(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
    // Full queue stalls, then releases.
    add(1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    // stack_full rising right after a write (rr_ptr = 1 here).
    add(1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1, 1'b0);
    add(1'b0, 4'b0011, 1'b1, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].restart) do_reset();
      bus.req        = vecs[i].req;
      bus.stack_full = vecs[i].sf;
      expect_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].write, vecs[i].blocked);
      @(posedge clk);
      #1;
      check_out();
      @(negedge clk);
    end

    // Reset asserted between edges while a grant is in flight.
    do_reset();
    bus.req = 4'b0100;
    expect_out("midrst_pre", 4'b0100, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_out();
    #2;
    reset = 1'b0;
    #1;
    cmp("midrst_grant", 32'(bus.grant),          32'd0);
    cmp("midrst_write", 32'(bus.write_to_stack), 32'd0);
    cmp("midrst_data",  32'(bus.data_to_stack),  32'd0);
    @(negedge clk);
    reset     = 1'b1;
    last_data = '0;
    expect_out("midrst_post", 4'b0100, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
    bus.req = '0;

    // 33 words into a 32-deep queue.
    do_reset();
    pend        = '{9, 8, 8, 8};
    written     = 0;
    bad         = 0;
    full_cycles = 0;
    for (int c = 0; c < 300 && full_cycles < 3; c++) begin
      for (int i = 0; i < n; i++) bus.req[i] = (pend[i] > 0);
      bus.stack_full = (written >= 32);
      sf_at_edge     = bus.stack_full;
      @(posedge clk);
      #1;
      if (bus.write_to_stack) begin
        if (sf_at_edge) bad++;
        written++;
        cmp("q_data", 32'(bus.data_to_stack), 32'(pick_word(bus.grant)));
        for (int i = 0; i < n; i++) begin
          if (bus.grant[i]) pend[i]--;
        end
      end
      if (bus.blocked) full_cycles++;
      @(negedge clk);
    end
    left = 0;
    for (int i = 0; i < n; i++) left += pend[i];
    cmp("q_writes",      32'(written),     32'd32);
    cmp("q_write_full",  32'(bad),         32'd0);
    cmp("q_full_cycles", 32'(full_cycles), 32'd3);
    cmp("q_blocked",     32'(bus.blocked), 32'd1);
    cmp("q_left",        32'(left),        32'd1);
    bus.req = '0;

    cmp("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
